// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// State enum plus the HOLD_CYCLES clamp.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT,
    GAP,
    RUN,
    SHUTDOWN
  } state_t;

  // A zero hold time still needs one cycle of full reset.
  function automatic int clamp_hold(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/ready_sync.sv
// Two-flop synchronizer bank, async active-low reset to 0.
// Ports: clk, rst_n, d (async in), q (synced out).
module ready_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset release with soft-reset shutdown.
// Ports: clk, reset_n, soft_req/soft_ack, domain_ready in,
// domain_reset/stage/all_up/timeout_err out (all registered).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         soft_req,
  output logic                         soft_ack,
  input  logic [NUM_DOMAINS-1:0]       domain_ready,
  output logic [NUM_DOMAINS-1:0]       domain_reset,
  output logic [$clog2(NUM_DOMAINS):0] stage,
  output logic                         all_up,
  output logic                         timeout_err
);

  localparam int N  = NUM_DOMAINS;
  localparam int SW = $clog2(N) + 1;
  localparam int HOLD_EFF = clamp_hold(HOLD_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOP_IDX =
    CNT_W'(N - 1);
  localparam logic [SW-1:0] LAST_DOM = SW'(N - 1);
  localparam logic [SW-1:0] RUN_STG  = SW'(N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     rst_q, rst_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic             up_q, up_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic [N-1:0]     rdy_s;
  logic             rdy_cur;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] cnt_dn;
  logic [SW-1:0]    stage_nx;

  ready_sync #(
    .W (N)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (domain_ready),
    .q     (rdy_s)
  );

  assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign cnt_dn   = cnt_q - 1'b1;
  assign stage_nx = stage_q + 1'b1;

  always_comb begin
    rdy_cur = 1'b0;
    for (int i = 0; i < N; i++)
      if (SW'(i) == stage_q) rdy_cur = rdy_s[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= '1;
      stage_q <= '0;
      up_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      stage_q <= stage_d;
      up_q    <= up_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_sat;
    rst_d   = rst_q;
    stage_d = stage_q;
    up_d    = up_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          rst_d[0] = 1'b0;
          stage_d  = '0;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (rdy_cur || cnt_q == ACK_LAST) begin
          if (!rdy_cur) err_d = 1'b1;
          cnt_d = '0;
          if (stage_q == LAST_DOM) begin
            state_d = RUN;
            up_d    = 1'b1;
            stage_d = RUN_STG;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          for (int i = 0; i < N; i++)
            if (SW'(i) == stage_nx) rst_d[i] = 1'b0;
          stage_d = stage_nx;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (soft_req) begin
          up_d       = 1'b0;
          rst_d[N-1] = 1'b1;
          if (N == 1) begin
            ack_d   = 1'b1;
            stage_d = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            // counter tracks the index just re-asserted
            cnt_d   = TOP_IDX;
            state_d = SHUTDOWN;
          end
        end
      end
      SHUTDOWN: begin
        for (int i = 0; i < N; i++)
          if (CNT_W'(i) == cnt_dn) rst_d[i] = 1'b1;
        cnt_d = cnt_dn;
        if (cnt_dn == '0) begin
          ack_d   = 1'b1;
          stage_d = '0;
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign domain_reset = rst_q;
  assign stage        = stage_q;
  assign all_up       = up_q;
  assign soft_ack     = ack_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// Timestamp-based reference model plus literal timing pins.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int H  = 10;
  localparam int G  = 16;
  localparam int A  = 255;
  localparam int SW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          soft_req = 1'b0;
  logic          soft_ack;
  logic [N-1:0]  domain_ready = '0;
  logic [N-1:0]  domain_reset;
  logic [SW-1:0] stage;
  logic          all_up;
  logic          timeout_err;

  reset_sequencer #(
    .NUM_DOMAINS (N),
    .HOLD_CYCLES (H),
    .STAGE_GAP   (G),
    .ACK_TIMEOUT (A),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_req     (soft_req),
    .soft_ack     (soft_ack),
    .domain_ready (domain_ready),
    .domain_reset (domain_reset),
    .stage        (stage),
    .all_up       (all_up),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: absolute edge times since reset release
  int           n;
  int           cur;
  bit           pend;
  int           t_rel;
  int           t_give;
  int           down;
  bit [N-1:0]   h1, h2;
  logic [N-1:0] m_rst;
  int           m_stage;
  bit           m_up, m_ack, m_err;

  // observed DUT event times
  int           fall_t[N];
  int           rise_t[N];
  int           ack_t, up_t, dn_t;
  int           ack_cnt, up_cyc;
  logic [N-1:0] prev_rst;
  logic         prev_up;

  function automatic bit bitat(input logic [N-1:0] v,
                               input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    n = 0; cur = 0; pend = 1; t_rel = H; down = 0;
    h1 = '0; h2 = '0;
    m_rst = '1; m_stage = 0;
    m_up = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic shut_one();
    m_rst = m_rst | (N'(1) << down);
    if (down == 0) begin
      m_ack = 1; cur = 0; pend = 1;
      t_rel = n + H; m_stage = 0;
    end else begin
      down--;
    end
  endtask

  task automatic model_step();
    bit [N-1:0] sy;
    bit         r;
    sy = h2; h2 = h1; h1 = domain_ready;
    n++;
    m_ack = 0;
    if (cur < N) begin
      r = bitat(sy, cur);
      if (pend) begin
        if (n == t_rel) begin
          m_rst = m_rst & ~(N'(1) << cur);
          m_stage = cur; pend = 0;
          t_give = n + A;
        end
      end else if (r || n == t_give) begin
        if (!r) m_err = 1;
        if (cur == N - 1) begin
          cur = N; m_up = 1; m_stage = N;
        end else begin
          cur++; pend = 1; t_rel = n + G;
        end
      end
    end else if (cur == N) begin
      if (soft_req) begin
        m_up = 0; down = N - 1; cur = N + 1;
        shut_one();
      end
    end else begin
      shut_one();
    end
  endtask

  task automatic clr_events();
    for (int i = 0; i < N; i++) begin
      fall_t[i] = -1; rise_t[i] = -1;
    end
    ack_t = -1; up_t = -1; dn_t = -1;
    ack_cnt = 0; up_cyc = 0;
    prev_rst = domain_reset; prev_up = all_up;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  // one clock: model on posedge, compare on negedge
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    checks++;
    if ({domain_reset, stage, all_up, soft_ack,
         timeout_err} !==
        {m_rst, SW'(m_stage), m_up, m_ack, m_err}) begin
      errors++;
      $display("FAIL cycle n=%0d got rst=%b stg=%0d up=%b ack=%b err=%b exp rst=%b stg=%0d up=%b ack=%b err=%b",
               n, domain_reset, stage, all_up, soft_ack,
               timeout_err, m_rst, m_stage, m_up, m_ack,
               m_err);
    end
    for (int i = 0; i < N; i++) begin
      if (bitat(prev_rst, i) && !bitat(domain_reset, i))
        fall_t[i] = n;
      if (!bitat(prev_rst, i) && bitat(domain_reset, i))
        rise_t[i] = n;
    end
    if (soft_ack) begin ack_t = n; ack_cnt++; end
    if (all_up && !prev_up) up_t = n;
    if (!all_up && prev_up) dn_t = n;
    if (all_up) up_cyc++;
    prev_rst = domain_reset;
    prev_up  = all_up;
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_domain_reset", 32'(domain_reset), 32'hF);
    check("rst_stage", 32'(stage), 0);
    check("rst_all_up", 32'(all_up), 0);
    check("rst_soft_ack", 32'(soft_ack), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    reset_n = 1'b1;
    clr_events();
  endtask

  task automatic run_until_up(input string nm,
                              input int budget);
    int k;
    k = 0;
    while (!all_up && k < budget) begin
      tick();
      k++;
    end
    check(nm, 32'(all_up), 1);
  endtask

  initial begin
    int base;
    model_reset();
    clr_events();

    // power-up, ready tied high, soft pulse in WAIT
    domain_ready = '1;
    do_reset();
    for (int k = 0; k < 70 && !all_up; k++) begin
      tick();
      soft_req = (n == 10);
    end
    soft_req = 1'b0;
    check("pu_up_reached", 32'(all_up), 1);
    check("pu_fall0", fall_t[0], 10);
    check("pu_fall1", fall_t[1], 27);
    check("pu_fall2", fall_t[2], 44);
    check("pu_fall3", fall_t[3], 61);
    check("pu_up_at", up_t, 62);
    check("pu_err", 32'(timeout_err), 0);

    // single-cycle soft request
    for (int k = 0; k < 5; k++) tick();
    clr_events();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    base = n;
    for (int k = 0; k < 4; k++) tick();
    check("sd_up_fall", dn_t, base);
    check("sd_rise3", rise_t[3], base);
    check("sd_rise2", rise_t[2], base + 1);
    check("sd_rise1", rise_t[1], base + 2);
    check("sd_rise0", rise_t[0], base + 3);
    check("sd_ack_at", ack_t, base + 3);
    check("sd_ack_cnt", ack_cnt, 1);
    base = base + 3;
    run_until_up("sd_up_reached", 200);
    check("sd_fall0", fall_t[0], base + 10);
    check("sd_fall3", fall_t[3], base + 61);
    check("sd_up_at", up_t, base + 62);
    check("sd_ack_once", ack_cnt, 1);

    // soft request held: continuous loop
    clr_events();
    soft_req = 1'b1;
    for (int k = 0; k < 198; k++) tick();
    soft_req = 1'b0;
    check("loop_acks", ack_cnt, 3);
    check("loop_up_cycles", up_cyc, 3);
    run_until_up("loop_up_reached", 200);

    // async reset in the middle of a GAP
    do_reset();
    while (fall_t[1] < 0 && n < 100) tick();
    for (int k = 0; k < 5; k++) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_all", 32'(domain_reset), 32'hF);
    check("async_stage", 32'(stage), 0);
    check("async_up", 32'(all_up), 0);
    tick();
    tick();
    reset_n = 1'b1;
    clr_events();
    run_until_up("async_up_reached", 200);
    check("async_fall0", fall_t[0], 10);
    check("async_up_at", up_t, 62);

    // domain 2 never ready: timeout
    domain_ready = 4'b1011;
    do_reset();
    run_until_up("to_up_reached", 1000);
    check("to_gap", fall_t[3] - fall_t[2], A + G);
    check("to_err", 32'(timeout_err), 1);
    domain_ready = '1;
    for (int k = 0; k < 20; k++) tick();
    check("to_err_sticky", 32'(timeout_err), 1);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 8000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 4)
          domain_ready = domain_ready ^ (N'(1) << i);
      if ($urandom_range(0, 63) == 0)
        soft_req = ~soft_req;
      if ($urandom_range(0, 2999) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rnd_async_rst", 32'(domain_reset), 32'hF);
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Multi-domain reset controller. Generates ordered, per-domain active-high resets from one clock and an asynchronous active-low board reset.
- Releases domains one at a time: hold, release, wait for the domain's ready, gap, then the next domain.
- Accepts a software reset request. Re-asserts the domains in reverse order, then re-runs the power-up sequence.
- Sits at the top level and feeds every subsystem reset.

Parameters:
- NUM_DOMAINS, 4, number of reset domains (>=1)
- HOLD_CYCLES, 10, cycles all domains stay in reset before the first release (0 treated as 1)
- STAGE_GAP, 16, cycles between a domain's ready and the next domain's release (>=1)
- ACK_TIMEOUT, 255, max cycles waiting for a domain's ready before giving up on it
- CNT_W, 16, internal counter width; must hold max(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- soft_req  in  1  software reset request, level
- soft_ack  out  1  one-cycle pulse: shutdown complete, request accepted
- domain_ready  in  NUM_DOMAINS  per-domain "out of reset and alive"; may be asynchronous
- domain_reset  out  NUM_DOMAINS  per-domain reset, active-high, registered
- stage  out  $clog2(NUM_DOMAINS)+1  index of the domain currently being released/awaited; NUM_DOMAINS when in RUN
- all_up  out  1  all domains released and ready
- timeout_err  out  1  sticky: some domain missed ACK_TIMEOUT

Behaviour:
- Async reset (reset_n=0): domain_reset all 1, all_up 0, soft_ack 0, timeout_err 0, stage 0, counter 0, state HOLD. All outputs are registered.
- domain_ready passes through a 2-flop synchronizer (reset to 0) before use: +2 cycles latency.
- HOLD: all domain_reset=1; counter counts 0..HOLD_CYCLES-1. On the edge with counter==HOLD_CYCLES-1: clear domain_reset[0], stage=0, go WAIT.
- WAIT(stage i): counter increments each cycle.
  - Synced ready[i]=1 on an edge: leave WAIT.
  - counter reaches ACK_TIMEOUT-1 first: set timeout_err, leave anyway.
  - Leaving with i<NUM_DOMAINS-1: go GAP, counter=0.
  - Leaving with i==NUM_DOMAINS-1: go RUN; all_up=1 and stage=NUM_DOMAINS on that edge.
- GAP: count STAGE_GAP cycles. On the edge with counter==STAGE_GAP-1: clear domain_reset[i+1], stage=i+1, go WAIT, counter=0.
- Released domains stay released. domain_reset bits only fall in ascending order during power-up.
- RUN: holds until soft_req=1 is sampled. Then all_up falls on that edge and the block goes SHUTDOWN.
- SHUTDOWN: sets domain_reset[NUM_DOMAINS-1] on entry, then one lower index per cycle. On the edge that sets domain_reset[0]:
  - pulse soft_ack (exactly 1 cycle);
  - go HOLD, counter=0;
  - the full power-up sequence follows.
- soft_req is ignored outside RUN. A soft_req still high when RUN is re-entered triggers another cycle. The requester must drop soft_req after soft_ack.
- A domain_ready dropping after release is ignored; no re-sequencing.
- timeout_err clears only on reset_n.
- reset_n asserted mid-sequence or mid-shutdown: immediate return to reset values, with all domain_reset=1 asynchronously.
- Counter saturates at all-ones, never wraps.

Decomposition:
- Package reset_seq_pkg:
  - state enum {HOLD, WAIT, GAP, RUN, SHUTDOWN};
  - clamp helper for HOLD_CYCLES=0.
- Sub-module ready_sync: parameterised-width 2-flop synchronizer, async active-low reset to 0, one instance for domain_ready.

Test Plan:
- Defaults, domain_ready tied 1 → domain_reset[0..3] fall after posedges 10, 27, 44, 61 counted from reset_n release; all_up rises after posedge 62; timeout_err stays 0.
- domain_ready[2] held 0 → domain_reset[3] falls 255+16 cycles after domain_reset[2] falls; timeout_err=1 and stays 1; all_up still reaches 1.
- In RUN, pulse soft_req high for 1 cycle → all_up falls at the next edge.
  - domain_reset[3], [2], [1], [0] rise on 4 consecutive edges.
  - soft_ack is high for exactly one cycle, coincident with domain_reset[0] rising.
  - The power-up timing of case 1 then repeats.
- Hold soft_req=1 permanently → continuous shutdown/power-up loop, with one soft_ack per loop and all_up high 1 cycle per loop.
- Assert reset_n mid-GAP after domain_reset[1] falls → all domain_reset=1 asynchronously before the next clk edge.
  - stage=0, counter cleared.
  - Sequence restarts cleanly after release.
- soft_req pulsed during WAIT → ignored; sequence timing unchanged from case 1.
